// File: rtl/signal_sched_pkg.sv
// Shared types and constants for the A/B intersection phase scheduler.
//   state_e  : phase encoding, also exported on the phase observability port
//   lamp_t   : per-state lamp pattern {Ago,Ayel,Astop,Bgo,Byel,Bstop}
//   lamp_of  : Moore decode from phase to lamp pattern
package signal_sched_pkg;

    localparam int unsigned PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        INIT_RED = 3'd0,
        A_GREEN  = 3'd1,
        A_YEL    = 3'd2,
        A_CLR    = 3'd3,
        B_GREEN  = 3'd4,
        B_YEL    = 3'd5,
        B_CLR    = 3'd6
    } state_e;

    typedef struct packed {
        logic a_go;
        logic a_yel;
        logic a_stop;
        logic b_go;
        logic b_yel;
        logic b_stop;
    } lamp_t;

    localparam lamp_t LAMP_ALL_RED = 6'b001_001;
    localparam lamp_t LAMP_A_GREEN = 6'b100_001;
    localparam lamp_t LAMP_A_YEL   = 6'b010_001;
    localparam lamp_t LAMP_B_GREEN = 6'b001_100;
    localparam lamp_t LAMP_B_YEL   = 6'b001_010;

    // Clearance, start-up and any unexpected encoding show red both ways.
    function automatic lamp_t lamp_of(input state_e s);
        lamp_t l;
        case (s)
            A_GREEN: l = LAMP_A_GREEN;
            A_YEL:   l = LAMP_A_YEL;
            B_GREEN: l = LAMP_B_GREEN;
            B_YEL:   l = LAMP_B_YEL;
            default: l = LAMP_ALL_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/signal_sched_if.sv
// Request/lamp bundle between the demand sources and the scheduler.
//   master : drives reqA/reqB, observes lamps, acks and phase
//   slave  : the scheduler; samples requests, drives everything else
interface signal_sched_if;
    import signal_sched_pkg::*;

    logic               reqA;
    logic               reqB;
    logic               Ago;
    logic               Ayel;
    logic               Astop;
    logic               Bgo;
    logic               Byel;
    logic               Bstop;
    logic               ackA;
    logic               ackB;
    logic [PHASE_W-1:0] phase;

    modport master (
        output reqA, reqB,
        input  Ago, Ayel, Astop, Bgo, Byel, Bstop, ackA, ackB, phase
    );

    modport slave (
        input  reqA, reqB,
        output Ago, Ayel, Astop, Bgo, Byel, Bstop, ackA, ackB, phase
    );
endinterface

// File: rtl/signal_sched_phase_timer.sv
// Elapsed-cycle counter for the current phase.
//   clk, reset : clock, async active-high reset (count -> 0)
//   clr_i      : restart from 0 on this edge (phase change)
//   cnt_o      : cycles spent in the current phase, saturating at all-ones
module signal_sched_phase_timer #(
    parameter int unsigned NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    output logic [NBITS-1:0] cnt_o
);

    logic [NBITS-1:0] cnt_q;
    logic [NBITS-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at the top.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + NBITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/signal_sched.sv
// Demand-driven phase scheduler for a two-approach (A/B) intersection.
// Latches per-approach demand and sequences green -> yellow -> all-red ->
// opposing green, honouring min green, demand extension and a max-green cap.
//   clk, reset : clock, async active-high reset
//   bus        : reqA/reqB in; lamps, ackA/ackB pulses and phase out
module signal_sched
    import signal_sched_pkg::*;
#(
    parameter int unsigned NBITS       = 32,
    parameter int unsigned T_MIN_GREEN = 32'h20,
    parameter int unsigned T_MAX_GREEN = 32'h80,
    parameter int unsigned T_YELLOW    = 32'h08,
    parameter int unsigned T_ALLRED    = 32'h04
) (
    input  logic          clk,
    input  logic          reset,
    signal_sched_if.slave bus
);

    // Exit thresholds: a T-cycle phase leaves on the edge where cnt == T-1.
    localparam logic [NBITS-1:0] MIN_LAST    = NBITS'(T_MIN_GREEN - 1);
    localparam logic [NBITS-1:0] MAX_LAST    = NBITS'(T_MAX_GREEN - 1);
    localparam logic [NBITS-1:0] YEL_LAST    = NBITS'(T_YELLOW - 1);
    localparam logic [NBITS-1:0] ALLRED_LAST = NBITS'(T_ALLRED - 1);

    state_e           state_q;
    state_e           state_d;
    logic             pend_a_q;
    logic             pend_a_d;
    logic             pend_b_q;
    logic             pend_b_d;
    lamp_t            lamp_q;
    lamp_t            lamp_d;
    logic             ack_a_q;
    logic             ack_a_d;
    logic             ack_b_q;
    logic             ack_b_d;
    logic             timer_clr;
    logic [NBITS-1:0] cnt;
    logic             a_green_done;
    logic             b_green_done;
    logic             yel_done;
    logic             allred_done;
    logic             enter_a;
    logic             enter_b;

    signal_sched_phase_timer #(
        .NBITS (NBITS)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr_i (timer_clr),
        .cnt_o (cnt)
    );

    // Green yields only to pending opposing demand, after min green, and
    // keeps extending while its own demand persists until the max cap.
    always_comb begin
        a_green_done = pend_b_q && (cnt >= MIN_LAST) && (!bus.reqA || (cnt >= MAX_LAST));
        b_green_done = pend_a_q && (cnt >= MIN_LAST) && (!bus.reqB || (cnt >= MAX_LAST));
        yel_done     = (cnt == YEL_LAST);
        allred_done  = (cnt == ALLRED_LAST);
    end

    // Next state, pending flags and the next registered output image.
    always_comb begin
        state_d   = state_q;
        pend_a_d  = pend_a_q;
        pend_b_d  = pend_b_q;
        enter_a   = 1'b0;
        enter_b   = 1'b0;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        lamp_d    = LAMP_ALL_RED;
        timer_clr = 1'b0;

        case (state_q)
            INIT_RED: if (allred_done)  state_d = A_GREEN;
            A_GREEN:  if (a_green_done) state_d = A_YEL;
            A_YEL:    if (yel_done)     state_d = A_CLR;
            A_CLR:    if (allred_done)  state_d = B_GREEN;
            B_GREEN:  if (b_green_done) state_d = B_YEL;
            B_YEL:    if (yel_done)     state_d = B_CLR;
            B_CLR:    if (allred_done)  state_d = A_GREEN;
            default:                    state_d = INIT_RED;
        endcase

        // Demand is latched only while the approach is not being served.
        if (bus.reqA && (state_q != A_GREEN)) pend_a_d = 1'b1;
        if (bus.reqB && (state_q != B_GREEN)) pend_b_d = 1'b1;

        // Entering green serves the demand; the clear overrides a same-edge set.
        enter_a = (state_d == A_GREEN) && (state_q != A_GREEN);
        enter_b = (state_d == B_GREEN) && (state_q != B_GREEN);
        if (enter_a) pend_a_d = 1'b0;
        if (enter_b) pend_b_d = 1'b0;

        ack_a_d   = enter_a;
        ack_b_d   = enter_b;
        lamp_d    = lamp_of(state_d);
        timer_clr = (state_d != state_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= INIT_RED;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            lamp_q   <= LAMP_ALL_RED;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            lamp_q   <= lamp_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
        end
    end

    assign bus.Ago   = lamp_q.a_go;
    assign bus.Ayel  = lamp_q.a_yel;
    assign bus.Astop = lamp_q.a_stop;
    assign bus.Bgo   = lamp_q.b_go;
    assign bus.Byel  = lamp_q.b_yel;
    assign bus.Bstop = lamp_q.b_stop;
    assign bus.ackA  = ack_a_q;
    assign bus.ackB  = ack_b_q;
    assign bus.phase = PHASE_W'(state_q);

endmodule
